// File: rtl/lab5_mcore_mem_arb_pkg.sv
// Shared definitions for the lab5 multicore memory arbiter: memory message
// widths (vc-mem-msgs layout with opaque 8, addr 32, data 32) and port ids.
package lab5_mcore_mem_arb_pkg;

  localparam int unsigned c_opaque_nbits = 8;
  localparam int unsigned c_addr_nbits   = 32;
  localparam int unsigned c_data_nbits   = 32;
  localparam int unsigned c_len_nbits    = $clog2(c_data_nbits / 8);

  // req: type(3) opaque addr len data ; resp: type(3) opaque test(2) len data
  localparam int unsigned c_req_msg_nbits  = 3 + c_opaque_nbits + c_addr_nbits + c_len_nbits + c_data_nbits;
  localparam int unsigned c_resp_msg_nbits = 3 + c_opaque_nbits + 2 + c_len_nbits + c_data_nbits;

  typedef enum logic {
    PORT_IMEM = 1'b0,
    PORT_DMEM = 1'b1
  } port_t;

endpackage

// File: rtl/lab5_mcore_mem_arb_tag_fifo.sv
// Tag FIFO remembering which port issued each outstanding memory request.
// Full blocks enqueue even when a dequeue happens in the same cycle.
module lab5_mcore_mem_arb_tag_fifo #(
  parameter int unsigned p_depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_val,
  output logic                     enq_rdy,
  input  logic                     enq_msg,
  output logic                     deq_val,
  input  logic                     deq_rdy,
  output logic                     deq_msg,
  output logic [$clog2(p_depth):0] occupancy
);

  localparam int unsigned c_ptr_nbits = $clog2(p_depth);
  localparam logic [c_ptr_nbits:0] c_full = (c_ptr_nbits + 1)'(p_depth);

  logic [p_depth-1:0]     entries;
  logic [c_ptr_nbits-1:0] wr_ptr;
  logic [c_ptr_nbits-1:0] rd_ptr;
  logic [c_ptr_nbits:0]   count;
  logic                   enq_fire;
  logic                   deq_fire;

  assign enq_rdy   = (count != c_full);
  assign deq_val   = (count != '0);
  assign deq_msg   = entries[rd_ptr];
  assign occupancy = count;
  assign enq_fire  = enq_val && enq_rdy;
  assign deq_fire  = deq_val && deq_rdy;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) begin
        entries[wr_ptr] <= enq_msg;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (deq_fire)
        rd_ptr <= rd_ptr + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lab5_mcore_mem_arb.sv
// Round-robin arbiter sharing one in-order memory port between imem and dmem;
// responses are routed back using a FIFO of issuing-port tags.
module lab5_mcore_mem_arb
  import lab5_mcore_mem_arb_pkg::*;
#(
  parameter int unsigned p_max_inflight = 4
) (
  input  logic                                clk,
  input  logic                                reset,

  input  logic [c_req_msg_nbits-1:0]          ireq_msg,
  input  logic                                ireq_val,
  output logic                                ireq_rdy,

  input  logic [c_req_msg_nbits-1:0]          dreq_msg,
  input  logic                                dreq_val,
  output logic                                dreq_rdy,

  output logic [c_resp_msg_nbits-1:0]         iresp_msg,
  output logic                                iresp_val,
  input  logic                                iresp_rdy,

  output logic [c_resp_msg_nbits-1:0]         dresp_msg,
  output logic                                dresp_val,
  input  logic                                dresp_rdy,

  output logic [c_req_msg_nbits-1:0]          memreq_msg,
  output logic                                memreq_val,
  input  logic                                memreq_rdy,

  input  logic [c_resp_msg_nbits-1:0]         memresp_msg,
  input  logic                                memresp_val,
  output logic                                memresp_rdy,

  output logic [$clog2(p_max_inflight):0]     inflight
);

  port_t prio;
  port_t grant;
  port_t head;
  logic  can_issue;
  logic  req_fire;
  logic  resp_fire;
  logic  resp_nonempty;
  logic  tag_deq_val;
  logic  tag_deq_msg;

  assign grant = (dreq_val && (!ireq_val || prio == PORT_DMEM)) ? PORT_DMEM : PORT_IMEM;

  // Outgoing val/rdy are forced low while reset is held, including the first
  // reset cycle before the FIFO has been cleared.
  assign memreq_val = !reset && (ireq_val || dreq_val) && can_issue;
  assign memreq_msg = (grant == PORT_DMEM) ? dreq_msg : ireq_msg;
  assign ireq_rdy   = !reset && can_issue && memreq_rdy && (grant == PORT_IMEM);
  assign dreq_rdy   = !reset && can_issue && memreq_rdy && (grant == PORT_DMEM);
  assign req_fire   = memreq_val && memreq_rdy;

  assign head          = port_t'(tag_deq_msg);
  assign resp_nonempty = !reset && tag_deq_val;
  assign iresp_msg     = memresp_msg;
  assign dresp_msg     = memresp_msg;
  assign iresp_val     = resp_nonempty && (head == PORT_IMEM) && memresp_val;
  assign dresp_val     = resp_nonempty && (head == PORT_DMEM) && memresp_val;
  assign memresp_rdy   = resp_nonempty && ((head == PORT_DMEM) ? dresp_rdy : iresp_rdy);
  assign resp_fire     = memresp_val && memresp_rdy;

  lab5_mcore_mem_arb_tag_fifo #(
    .p_depth (p_max_inflight)
  ) tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .enq_val   (req_fire),
    .enq_rdy   (can_issue),
    .enq_msg   (grant),
    .deq_val   (tag_deq_val),
    .deq_rdy   (resp_fire),
    .deq_msg   (tag_deq_msg),
    .occupancy (inflight)
  );

  always_ff @(posedge clk) begin
    if (reset)
      prio <= PORT_IMEM;
    else if (req_fire)
      prio <= (grant == PORT_IMEM) ? PORT_DMEM : PORT_IMEM;
  end

endmodule

// File: doc/lab5_mcore_mem_arb.md
LAB5_MCORE_MEM_ARB -- requirements
Module: lab5_mcore_mem_arb

Interface
REQ-001 The block SHALL expose parameter p_max_inflight, default 4, meaning the maximum number of outstanding memory requests (power of two, 2..16).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 ireq_msg/ireq_val/ireq_rdy  in/in/out  VC_MEM_REQ_MSG_NBITS(8,32,32)/1/1  processor imem request port (port 0).
REQ-005 dreq_msg/dreq_val/dreq_rdy  in/in/out  VC_MEM_REQ_MSG_NBITS(8,32,32)/1/1  processor dmem request port (port 1).
REQ-006 iresp_msg/iresp_val/iresp_rdy  out/out/in  VC_MEM_RESP_MSG_NBITS(8,32)/1/1  imem response port.
REQ-007 dresp_msg/dresp_val/dresp_rdy  out/out/in  VC_MEM_RESP_MSG_NBITS(8,32)/1/1  dmem response port.
REQ-008 memreq_msg/memreq_val/memreq_rdy  out/out/in  VC_MEM_REQ_MSG_NBITS(8,32,32)/1/1  shared memory request port.
REQ-009 memresp_msg/memresp_val/memresp_rdy  in/in/out  VC_MEM_RESP_MSG_NBITS(8,32)/1/1  shared memory response port.
REQ-010 inflight  output  $clog2(p_max_inflight)+1  count of outstanding requests.

Function
REQ-011 All ports SHALL use val/rdy handshakes; a transfer occurs in a cycle where val && rdy are both high.
REQ-012 The memory SHALL return responses in request order; the block relies on this and performs no reordering.
REQ-013 Request path SHALL be combinational (zero latency): memreq_msg = granted port's msg, unmodified (opaque preserved).
REQ-014 memreq_val SHALL be high iff at least one request val is high and inflight < p_max_inflight.
REQ-015 Grant SHALL be round-robin: priority register prio (1 bit) selects the higher-priority port; when both valid, prio port wins; when one valid, it wins.
REQ-016 ireq_rdy/dreq_rdy SHALL be high only for the granted port, and only when memreq_rdy && inflight < p_max_inflight; rdy SHALL NOT depend on the other port's rdy.
REQ-017 On each request transfer prio SHALL update to the non-winning port; with no transfer, prio holds.
REQ-018 Each request transfer SHALL push the winner's port id (0 or 1) into a tag FIFO of depth p_max_inflight.
REQ-019 Push SHALL be blocked when FIFO is full, even if a pop occurs in the same cycle (no full-bypass).
REQ-020 Response routing: if FIFO nonempty, memresp_msg SHALL be forwarded unmodified to the port named by FIFO head; that port's resp_val = memresp_val; the other port's resp_val = 0.
REQ-021 memresp_rdy SHALL equal FIFO nonempty && head port's resp_rdy.
REQ-022 If FIFO empty, memresp_rdy SHALL be 0 and both resp_val SHALL be 0 (spurious response is never consumed).
REQ-023 Each response transfer SHALL pop the FIFO head.
REQ-024 Simultaneous push and pop when not full SHALL leave inflight unchanged; FIFO pointers SHALL wrap modulo p_max_inflight.
REQ-025 inflight SHALL equal FIFO occupancy: +1 on push only, -1 on pop only.
REQ-026 Back-to-back transfers on one port (one per cycle) SHALL be supported with no bubble while capacity remains.

Reset
REQ-027 While reset is high: FIFO empty, inflight = 0, prio = 0 (imem favoured), all outgoing val and rdy = 0.
REQ-028 Reset asserted mid-operation SHALL discard all outstanding tags at the next edge; responses arriving afterwards fall under REQ-022.

Structure
REQ-029 Message widths SHALL come from the shared vc-mem-msgs definitions; port id constants (IMEM=0, DMEM=1) SHALL live in a shared lab5_mcore package header.
REQ-030 The tag FIFO SHALL be a sub-module lab5_mcore_mem_arb_tag_fifo (1-bit entries, parameterized depth, enq/deq val/rdy, occupancy output).

Verification
REQ-031 Single imem read addr 0x0000_1000 -> memreq carries identical msg same cycle; response data 0xdead_beef appears on iresp only; inflight 0->1->0.
REQ-032 Both ports valid continuously for 6 cycles, memory always ready -> grants alternate I,D,I,D,I,D starting with I after reset.
REQ-033 Issue 4 dmem requests with memresp_val held low -> 5th request stalled (dreq_rdy=0, memreq_val=0), inflight=4; one response pop in the same cycle still blocks the push.
REQ-034 Interleaved I,D,I outstanding, responses 0x11,0x22,0x33 returned in order with dresp_rdy low for 2 cycles -> 0x11 to iresp, memresp_rdy=0 two cycles, then 0x22 to dresp, 0x33 to iresp.
REQ-035 memresp_val asserted with FIFO empty -> memresp_rdy=0, iresp_val=dresp_val=0 indefinitely.
REQ-036 Reset asserted with 3 outstanding -> next cycle inflight=0, prio=0; subsequent request accepted normally.
